// File: rtl/pong_game_controller_if.sv
// rtl/pong_game_controller_if.sv - movement-block handshake between game controller and paddle/ball datapath
interface pong_game_controller_if;
  logic collided;
  logic missed_one;
  logic missed_two;
  logic ball_hold;
  logic paddle_en;

  modport master (
    output ball_hold,
    output paddle_en,
    input  collided,
    input  missed_one,
    input  missed_two
  );

  modport slave (
    input  ball_hold,
    input  paddle_en,
    output collided,
    output missed_one,
    output missed_two
  );
endinterface

// File: rtl/pong_game_controller.sv
// rtl/pong_game_controller.sv - Pong match sequencer: serve/play/point/over FSM, scores, rally and speed level
// Optional pause state and pause_btn port enabled by defining PONG_PAUSE_EN.
module pong_game_controller #(
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 90,
  parameter int WIN_SCORE      = 7,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          endofframe,
  input  logic                          start_btn,
`ifdef PONG_PAUSE_EN
  input  logic                          pause_btn,
`endif
  pong_game_controller_if.master        mv,
  output logic [3:0]                    score_one,
  output logic [3:0]                    score_two,
  output logic [7:0]                    rally,
  output logic [1:0]                    speed_level,
  output logic                          serve_dir,
  output logic                          game_over,
  output logic                          winner,
  output logic [2:0]                    state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0] LEVEL_MAX  = 2'(MAX_LEVEL);

  state_t     state_q, state_d;
  logic       ef_s1, ef_s2, ef_s3;
  logic       start_q, col_q, m1_q, m2_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] hit_q, hit_d;
  logic [7:0] rally_q, rally_d;
  logic [1:0] level_q, level_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic       dir_q, dir_d, over_q, over_d, win_q, win_d;
  logic       hold_q, hold_d, pen_q, pen_d;
  logic       frame_tick, start_pulse, col_pulse, m1_pulse, m2_pulse;

  assign frame_tick  = ef_s2 & ~ef_s3;
  assign start_pulse = start_btn & ~start_q;
  assign col_pulse   = mv.collided & ~col_q;
  assign m1_pulse    = mv.missed_one & ~m1_q;
  assign m2_pulse    = mv.missed_two & ~m2_q;

`ifdef PONG_PAUSE_EN
  logic pause_q, pause_pulse;
  assign pause_pulse = pause_btn & ~pause_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_btn;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      {ef_s1, ef_s2, ef_s3} <= 3'b000;
      {start_q, col_q, m1_q, m2_q} <= 4'b0000;
      cnt_q   <= 8'd0;
      hit_q   <= 4'd0;
      rally_q <= 8'd0;
      level_q <= 2'd0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      dir_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      hold_q  <= 1'b1;
      pen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      {ef_s1, ef_s2, ef_s3} <= {endofframe, ef_s1, ef_s2};
      {start_q, col_q, m1_q, m2_q} <= {start_btn, mv.collided, mv.missed_one, mv.missed_two};
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      rally_q <= rally_d;
      level_q <= level_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      over_q  <= over_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      pen_q   <= pen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    rally_d = rally_q;
    level_d = level_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    over_d  = over_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (start_pulse) begin
        state_d = SERVE;
        {s1_d, s2_d, rally_d, level_d, hit_d, cnt_d} = '0;
      end
      SERVE: if (frame_tick) begin
        if (cnt_q == SERVE_LAST) begin
          state_d = PLAY;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PLAY: begin
        // miss beats hit, and missed_one beats missed_two
        if (m1_pulse || m2_pulse) begin
          state_d = POINT;
          {rally_d, level_d, hit_d, cnt_d} = '0;
          if (m1_pulse) begin
            s2_d  = s2_q + 4'd1;
            dir_d = 1'b0;
          end else begin
            s1_d  = s1_q + 4'd1;
            dir_d = 1'b1;
          end
        end else if (col_pulse && rally_q != 8'hFF) begin
          rally_d = rally_q + 8'd1;
          if (hit_q == HIT_LAST) begin
            hit_d = 4'd0;
            if (level_q != LEVEL_MAX) level_d = level_q + 2'd1;
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_pulse) state_d = PAUSE;
`endif
      end
      POINT: begin
        if (s1_q == WIN || s2_q == WIN) begin
          state_d = OVER;
          over_d  = 1'b1;
          win_d   = (s2_q == WIN);
        end else if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            state_d = SERVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      OVER: if (start_pulse) begin
        state_d = IDLE;
        over_d  = 1'b0;
      end
`ifdef PONG_PAUSE_EN
      PAUSE: if (pause_pulse) state_d = PLAY;
`endif
      default: state_d = IDLE;
    endcase
    // controls are registered from the next state so they move with state
    hold_d = (state_d != PLAY);
    pen_d  = (state_d == SERVE) || (state_d == PLAY);
  end

  assign mv.ball_hold = hold_q;
  assign mv.paddle_en = pen_q;
  assign score_one    = s1_q;
  assign score_two    = s2_q;
  assign rally        = rally_q;
  assign speed_level  = level_q;
  assign serve_dir    = dir_q;
  assign game_over    = over_q;
  assign winner       = win_q;
  assign state        = state_q;

endmodule
